// File: rtl/mem0_frame_fetcher.sv
// rtl/mem0_frame_fetcher.sv - fetches image rows from MEM0 port B, streams them to the BNN core, writes back the class
module mem0_frame_fetcher #(
    parameter int                ROWS        = 28,
    parameter int                DATA_W      = 28,
    parameter int                ADDR_W      = 6,
    parameter int                RD_LAT      = 2,
    parameter int                CLASS_W     = 4,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = 6'd28
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iCLR,
    input  logic               iSTART,
    output logic [ADDR_W-1:0]  oMEM0ADDR,
    output logic               oMEM0Rd_EN,
    input  logic [DATA_W-1:0]  iMEM0RdDATA,
    output logic               oMEM0Wr_EN,
    output logic [DATA_W-1:0]  oMEM0WrDATA,
    output logic               oROW_VALID,
    output logic [DATA_W-1:0]  oROW_DATA,
    output logic [4:0]         oROW_IDX,
    input  logic               iROW_READY,
    input  logic               iRES_VALID,
    input  logic [CLASS_W-1:0] iRES_CLASS,
    output logic               oBUSY,
    output logic               oDONE
);

    localparam int                LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
    localparam logic [4:0]        ROW_LAST = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        PRESENT,
        WAIT_RES,
        WRITE,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [4:0]           row;
    logic [LAT_W-1:0]     lat_cnt;
    logic [CLASS_W-1:0]   class_q;
    logic [DATA_W-1:0]    row_data;
    logic                 rst_any;

    assign rst_any = iRST | iCLR;

    always_ff @(posedge iCLK) begin
        if (rst_any) begin
            state    <= IDLE;
            row      <= '0;
            lat_cnt  <= '0;
            class_q  <= '0;
            row_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                RD_WAIT: begin
                    // Capture exactly on the cycle the RAM output becomes valid.
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt  <= '0;
                        row_data <= iMEM0RdDATA;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    if (iROW_READY && (row != ROW_LAST)) begin
                        row <= row + 5'd1;
                    end
                end
                WAIT_RES: begin
                    if (iRES_VALID) begin
                        class_q <= iRES_CLASS;
                    end
                end
                DONE: begin
                    row <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        oMEM0Rd_EN  = 1'b0;
        oMEM0Wr_EN  = 1'b0;
        oMEM0ADDR   = '0;
        oMEM0WrDATA = '0;
        oROW_VALID  = 1'b0;
        oDONE       = 1'b0;
        case (state)
            IDLE: begin
                if (iSTART) begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                oMEM0Rd_EN = 1'b1;
                oMEM0ADDR  = ADDR_W'(row);
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                oROW_VALID = 1'b1;
                if (iROW_READY) begin
                    state_next = (row == ROW_LAST) ? WAIT_RES : RD_REQ;
                end
            end
            WAIT_RES: begin
                if (iRES_VALID) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                oMEM0Wr_EN  = 1'b1;
                oMEM0ADDR   = RESULT_ADDR;
                oMEM0WrDATA = {{(DATA_W-CLASS_W){1'b0}}, class_q};
                state_next  = DONE;
            end
            DONE: begin
                oDONE      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign oBUSY     = (state != IDLE);
    assign oROW_DATA = row_data;
    assign oROW_IDX  = row;

endmodule

// File: tb/tb_mem0_frame_fetcher.sv
// tb/tb_mem0_frame_fetcher.sv - randomized frame bench for mem0_frame_fetcher at RD_LAT 1, 2 and 3
module tb_mem0_frame_fetcher;

    localparam int NLANE  = 3;
    localparam int NFRAME = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NLANE; g++) begin : lane
        localparam int LAT = g + 1;

        logic        rst = 1'b1, clr = 1'b0, start = 1'b0, ready = 1'b1;
        logic        res_valid = 1'b0;
        logic [3:0]  res_class = '0;
        logic        rd_en, wr_en, valid, busy, done;
        logic [5:0]  addr;
        logic [27:0] rdata, wdata, row_data;
        logic [4:0]  idx;

        mem0_frame_fetcher #(.RD_LAT(LAT)) dut (
            .iCLK(clk), .iRST(rst), .iCLR(clr), .iSTART(start),
            .oMEM0ADDR(addr), .oMEM0Rd_EN(rd_en), .iMEM0RdDATA(rdata),
            .oMEM0Wr_EN(wr_en), .oMEM0WrDATA(wdata),
            .oROW_VALID(valid), .oROW_DATA(row_data), .oROW_IDX(idx),
            .iROW_READY(ready), .iRES_VALID(res_valid), .iRES_CLASS(res_class),
            .oBUSY(busy), .oDONE(done)
        );

        function automatic string t(input string s);
            return $sformatf("lat%0d.%s", LAT, s);
        endfunction

        // RAM model: data appears exactly LAT cycles after the read enable, junk otherwise.
        logic [27:0] img [0:63];
        logic [2:0]  pv = '0;
        logic [5:0]  pa [0:2];
        logic [27:0] junk = '0;
        always @(posedge clk) begin
            pv    <= {pv[1:0], rd_en};
            pa[0] <= addr;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
            junk  <= 28'($urandom);
        end
        assign rdata = pv[LAT-1] ? img[pa[LAT-1]] : junk;

        int         reads = 0, writes = 0, dones = 0, viol = 0;
        int         exp_row = 0, last_hs = 0, wr_cyc = 0, res_cyc = 0;
        bit         model_busy = 0, stalled = 0, held = 0, prev_rst = 0, armed = 0, fin = 0;
        logic [4:0] hold_idx;
        logic [27:0] hold_data;
        logic [3:0] exp_class = '0;

        always @(negedge clk) begin
            if (armed) begin
                if (prev_rst)
                    check_val(t("rst_zero"), {addr, rd_en, wr_en, wdata, valid, row_data, idx, busy, done}, '0);
                if (rd_en && wr_en) viol++;
                if (!rd_en && !wr_en && addr != 6'd0) viol++;
                if (busy !== model_busy) viol++;
                if (rd_en && valid) viol++;
                if (held) check_val(t("hold"), {valid, idx, row_data}, {1'b1, hold_idx, hold_data});
                held = 0;
                if (rd_en) begin
                    reads++;
                    check_val(t("rd_addr"), addr, exp_row);
                end
                if (valid && ready) begin
                    check_val(t("row_idx"), idx, exp_row);
                    check_val(t("row_data"), row_data, img[exp_row]);
                    if (!stalled) check_val(t("row_period"), cyc - last_hs, LAT + 2);
                    last_hs = cyc;
                    stalled = 0;
                    exp_row = (exp_row == 27) ? 0 : exp_row + 1;
                end else if (valid) begin
                    held      = 1;
                    hold_idx  = idx;
                    hold_data = row_data;
                    stalled   = 1;
                end
                if (wr_en) begin
                    writes++;
                    check_val(t("wr_addr"), addr, 28);
                    check_val(t("wr_data"), wdata, {24'b0, exp_class});
                    check_val(t("wr_lat"), cyc - res_cyc, 1);
                    wr_cyc = cyc;
                end
                if (done) begin
                    dones++;
                    check_val(t("done_lat"), cyc - wr_cyc, 1);
                end
            end
            prev_rst = rst | clr;
            if (rst | clr) begin
                armed      = 1;
                model_busy = 0;
                exp_row    = 0;
                held       = 0;
            end else if (done) begin
                model_busy = 0;
            end else if (start && !model_busy) begin
                model_busy = 1;
                last_hs    = cyc;
                stalled    = 0;
            end
        end

        int mode, pend, stall_left, cnt, r0, w0, d0, v0;
        bit got_last, early_sent, do_rst, aborted;

        initial begin
            for (int i = 0; i < 64; i++) img[i] = '0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            for (int f = 0; f < NFRAME; f++) begin
                mode = f % 5;
                for (int i = 0; i < 28; i++) img[i] = (f == 0) ? (28'h1 << i) : 28'($urandom);
                exp_class = (f == 0) ? 4'd7 : (mode == 4) ? 4'd3 : 4'($urandom);
                r0 = reads; w0 = writes; d0 = dones; v0 = viol;
                got_last = 0; early_sent = 0; do_rst = 0; aborted = 0;
                pend = -1; stall_left = 5; cnt = 0;
                start = 1'b1;
                while (1) begin
                    @(negedge clk);
                    if (done) break;
                    if (valid && ready && idx == 5'd27) begin
                        got_last = 1;
                        pend = $urandom_range(0, 4);
                    end
                    do_rst = (mode == 3) && valid && ready && idx == 5'd10;
                    @(posedge clk);
                    #1;
                    if (do_rst) begin
                        start = 1'b0; res_valid = 1'b0;
                        if (g == 1) clr = 1'b1; else rst = 1'b1;
                        @(posedge clk);
                        #1 rst = 1'b0; clr = 1'b0;
                        aborted = 1;
                        break;
                    end
                    start = (mode == 2 || mode == 4) ? ($urandom_range(0, 5) == 0) : 1'b0;
                    if (mode == 1) begin
                        ready = 1'b1;
                        if (valid && idx == 5'd13 && stall_left > 0) begin
                            ready = 1'b0;
                            stall_left--;
                        end
                    end else if (mode == 2) begin
                        ready = ($urandom_range(0, 2) != 0);
                    end else begin
                        ready = 1'b1;
                    end
                    res_valid = 1'b0;
                    if (pend == 0) begin
                        res_valid = 1'b1;
                        res_class = exp_class;
                        res_cyc   = cyc;
                        pend      = -1;
                    end else if (pend > 0) begin
                        pend--;
                    end else if (!got_last) begin
                        if (mode == 4 && valid && idx == 5'd5 && !early_sent) begin
                            res_valid  = 1'b1;
                            res_class  = ~exp_class;
                            early_sent = 1;
                        end else if (mode == 2 && $urandom_range(0, 9) == 0) begin
                            res_valid = 1'b1;
                            res_class = 4'($urandom);
                        end
                    end
                    cnt++;
                    if (cnt > 3000) begin
                        check_val(t("frame_timeout"), 1, 0);
                        break;
                    end
                end
                if (!aborted) begin
                    @(posedge clk);
                    #1 start = 1'b0; res_valid = 1'b0;
                end
                check_val(t("reads"), reads - r0, aborted ? 12 : 28);
                check_val(t("writes"), writes - w0, aborted ? 0 : 1);
                check_val(t("dones"), dones - d0, aborted ? 0 : 1);
                check_val(t("protocol"), viol - v0, 0);
            end
            repeat (4) @(posedge clk);
            fin = 1;
        end
    end

    initial begin
        bit all_fin;
        all_fin = 0;
        for (int i = 0; i < 40000 && !all_fin; i++) begin
            @(posedge clk);
            all_fin = lane[0].fin && lane[1].fin && lane[2].fin;
        end
        if (!all_fin) check_val("global_timeout", 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
